// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: opcode constants,
// default data width and the checker state encoding.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 10;
    localparam int ALU_CTL_W         = 3;

    typedef enum logic [ALU_CTL_W-1:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/alu_result_checker_if.sv
// Transaction bus between an ALU under observation and the result checker.
// The master side presents one ALU transaction per in_valid cycle; the
// slave side returns the per-transaction check pulse and verdict.
interface alu_result_checker_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
);
    logic                 in_valid;
    logic [ALU_CTL_W-1:0] ctl;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic [WIDTH-1:0]     out;
    logic                 carry_out;
    logic                 zero;
    logic                 check_valid;
    logic                 mismatch;

    modport master (
        output in_valid, ctl, in1, in2, out, carry_out, zero,
        input  check_valid, mismatch
    );

    modport slave (
        input  in_valid, ctl, in1, in2, out, carry_out, zero,
        output check_valid, mismatch
    );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational ALU reference: expected result, carry/borrow and zero flag
// for a given opcode and operand pair. Arithmetic uses a WIDTH+1-bit
// intermediate so the carry/borrow is taken before any truncation.
module alu_ref_model import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic [ALU_CTL_W-1:0] ctl,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [WIDTH-1:0]     exp_out,
    output logic                 exp_carry,
    output logic                 exp_zero
);
    logic [WIDTH:0] sum;

    // Decode the opcode into the expected result and carry.
    always_comb begin
        sum       = '0;
        exp_out   = '0;
        exp_carry = 1'b0;
        case (alu_op_e'(ctl))
            ALU_AND:  exp_out = in1 & in2;
            ALU_OR:   exp_out = in1 | in2;
            ALU_ADD: begin
                sum       = {1'b0, in1} + {1'b0, in2};
                exp_out   = sum[WIDTH-1:0];
                exp_carry = sum[WIDTH];
            end
            ALU_XOR:  exp_out = in1 ^ in2;
            ALU_NOR:  exp_out = ~(in1 | in2);
            ALU_SLTU: exp_out = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            ALU_SUB: begin
                // Bit WIDTH of the extended difference is the borrow (in1 < in2).
                sum       = {1'b0, in1} - {1'b0, in2};
                exp_out   = sum[WIDTH-1:0];
                exp_carry = sum[WIDTH];
            end
            ALU_SLT:  exp_out = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default:  exp_out = '0;
        endcase
    end

    assign exp_zero = (exp_out == '0);
endmodule

// File: rtl/alu_result_checker.sv
// ALU result checker: registers each observed ALU transaction, recomputes
// the expected result one stage later and reports pass/fail two cycles
// after acceptance. Keeps saturating pass/fail totals, captures the first
// failing transaction and can halt on the first failure.
// Build option: define ALU_CHK_CARRY_EN to include carry_out in the compare.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_RUN    | transactions accepted and checked
// ST_HALTED | stopped after a failure; inputs ignored, pipeline dropped
module alu_result_checker import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_checker_if.slave  bus,
    input  logic                 stop_on_fail,
    input  logic                 clear,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 halted,
    output logic [ALU_CTL_W-1:0] first_fail_ctl,
    output logic [WIDTH-1:0]     first_fail_in1,
    output logic [WIDTH-1:0]     first_fail_in2,
    output logic [WIDTH-1:0]     first_fail_out
);
    chk_state_e           state_q, state_d;
    logic                 accept, check_en, fail;
    logic                 s1_valid, s1_carry, s1_zero;
    logic [ALU_CTL_W-1:0] s1_ctl;
    logic [WIDTH-1:0]     s1_in1, s1_in2, s1_out;
    logic [WIDTH-1:0]     exp_out;
    logic                 exp_carry, exp_zero;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .ctl       (s1_ctl),
        .in1       (s1_in1),
        .in2       (s1_in2),
        .exp_out   (exp_out),
        .exp_carry (exp_carry),
        .exp_zero  (exp_zero)
    );

`ifdef ALU_CHK_CARRY_EN
    assign fail = (s1_out != exp_out) || (s1_zero != exp_zero) || (s1_carry != exp_carry);
`else
    logic unused_carry;
    assign unused_carry = s1_carry ^ exp_carry;
    assign fail = (s1_out != exp_out) || (s1_zero != exp_zero);
`endif

    // State register; reset and clear both return to RUN.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Next state: a failing check with stop_on_fail halts until cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (check_en && fail && stop_on_fail) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (clear) state_d = ST_RUN;
    end

    // State-dependent controls: only RUN accepts new work or completes checks.
    always_comb begin
        accept   = 1'b0;
        check_en = 1'b0;
        if (state_q == ST_RUN) begin
            accept   = bus.in_valid;
            check_en = s1_valid;
        end
    end

    assign halted = (state_q == ST_HALTED);

    // Stage 1: capture the observed transaction.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_valid <= 1'b0;
            s1_ctl   <= '0;
            s1_in1   <= '0;
            s1_in2   <= '0;
            s1_out   <= '0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ctl   <= bus.ctl;
                s1_in1   <= bus.in1;
                s1_in2   <= bus.in2;
                s1_out   <= bus.out;
                s1_carry <= bus.carry_out;
                s1_zero  <= bus.zero;
            end
        end
    end

    // Stage 2: publish the verdict and update totals; clear overrides a completing check.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bus.check_valid <= 1'b0;
            bus.mismatch    <= 1'b0;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_ctl  <= '0;
            first_fail_in1  <= '0;
            first_fail_in2  <= '0;
            first_fail_out  <= '0;
        end else begin
            bus.check_valid <= check_en;
            bus.mismatch    <= check_en && fail;
            if (check_en) begin
                if (fail) begin
                    if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                    // A zero fail total means no failure since reset/clear.
                    if (fail_count == '0) begin
                        first_fail_ctl <= s1_ctl;
                        first_fail_in1 <= s1_in1;
                        first_fail_in2 <= s1_in2;
                        first_fail_out <= s1_out;
                    end
                end else if (pass_count != '1) begin
                    pass_count <= pass_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized scoreboard bench for alu_result_checker: the stimulus side
// pushes the expected verdict and totals for every transaction the checker
// should report; a negedge monitor pops and compares on each check_valid.
module tb_alu_result_checker;
    import alu_pkg::*;

    localparam int WIDTH   = 10;
    localparam int CNT_W   = 16;
    localparam int MAXV    = 1 << WIDTH;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int mism;
        int pass_c;
        int fail_c;
        int halt;
        int ff_ctl;
        int ff_in1;
        int ff_in2;
        int ff_out;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             stop_on_fail;
    logic             clear;
    logic [CNT_W-1:0] pass_count, fail_count;
    logic             halted;
    logic [2:0]       first_fail_ctl;
    logic [WIDTH-1:0] first_fail_in1, first_fail_in2, first_fail_out;

    alu_result_checker_if #(.WIDTH(WIDTH)) bus ();

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .stop_on_fail   (stop_on_fail),
        .clear          (clear),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .halted         (halted),
        .first_fail_ctl (first_fail_ctl),
        .first_fail_in1 (first_fail_in1),
        .first_fail_in2 (first_fail_in2),
        .first_fail_out (first_fail_out)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    int m_pass, m_fail, m_halt, m_have_fail;
    int m_ff_ctl, m_ff_in1, m_ff_in2, m_ff_out;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_pass = 0; m_fail = 0; m_halt = 0; m_have_fail = 0;
        m_ff_ctl = 0; m_ff_in1 = 0; m_ff_in2 = 0; m_ff_out = 0;
    endfunction

    // Plain-arithmetic ALU behaviour.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output int c, output int z);
        int sa, sb;
        c = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin r = (a + b) % MAXV; c = (a + b >= MAXV) ? 1 : 0; end
            3: r = a ^ b;
            4: r = (MAXV - 1) - (a | b);
            5: r = (a < b) ? 1 : 0;
            6: begin r = (a - b + MAXV) % MAXV; c = (a < b) ? 1 : 0; end
            default: begin
                sa = (a >= MAXV / 2) ? a - MAXV : a;
                sb = (b >= MAXV / 2) ? b - MAXV : b;
                r  = (sa < sb) ? 1 : 0;
            end
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    function automatic int pick_operand();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return MAXV - 1;
            2:       return MAXV / 2;
            3:       return MAXV / 2 - 1;
            default: return int'($urandom_range(0, MAXV - 1));
        endcase
    endfunction

    // Present one transaction for one cycle and record what the checker must report.
    task automatic issue(input int op, input int a, input int b, input int o, input int c, input int z);
        int r, ec, ez, mism;
        exp_t e;
        bus.ctl       = 3'(op);
        bus.in1       = WIDTH'(a);
        bus.in2       = WIDTH'(b);
        bus.out       = WIDTH'(o);
        bus.carry_out = (c != 0);
        bus.zero      = (z != 0);
        bus.in_valid  = 1'b1;
        if (m_halt == 0) begin
            ref_alu(op, a, b, r, ec, ez);
            mism = (o != r || z != ez) ? 1 : 0;
`ifdef ALU_CHK_CARRY_EN
            if (c != ec) mism = 1;
`endif
            if (mism != 0) begin
                if (m_fail < CNT_MAX) m_fail++;
                if (m_have_fail == 0) begin
                    m_have_fail = 1;
                    m_ff_ctl = op; m_ff_in1 = a; m_ff_in2 = b; m_ff_out = o;
                end
                if (stop_on_fail) m_halt = 1;
            end else if (m_pass < CNT_MAX) begin
                m_pass++;
            end
            e = '{mism, m_pass, m_fail, m_halt, m_ff_ctl, m_ff_in1, m_ff_in2, m_ff_out};
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        chk({tag, "_check_valid"}, int'(bus.check_valid), 0);
        chk({tag, "_pass_count"}, int'(pass_count), 0);
        chk({tag, "_fail_count"}, int'(fail_count), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_ff_ctl"}, int'(first_fail_ctl), 0);
        chk({tag, "_ff_in1"}, int'(first_fail_in1), 0);
        chk({tag, "_ff_out"}, int'(first_fail_out), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
    endtask

    // Monitor: every reported check must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.check_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_check_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("mismatch", int'(bus.mismatch), e.mism);
                chk("pass_count", int'(pass_count), e.pass_c);
                chk("fail_count", int'(fail_count), e.fail_c);
                chk("halted", int'(halted), e.halt);
                chk("first_fail_ctl", int'(first_fail_ctl), e.ff_ctl);
                chk("first_fail_in1", int'(first_fail_in1), e.ff_in1);
                chk("first_fail_in2", int'(first_fail_in2), e.ff_in2);
                chk("first_fail_out", int'(first_fail_out), e.ff_out);
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; stop_on_fail = 1'b0;
        bus.in_valid = 1'b0; bus.ctl = '0; bus.in1 = '0; bus.in2 = '0;
        bus.out = '0; bus.carry_out = 1'b0; bus.zero = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_zero("reset");

        // ADD 512+256 with a two-cycle report latency.
        issue(2, 512, 256, 768, 0, 0);
        @(negedge clk);
        chk("latency_cycle1", int'(bus.check_valid), 0);
        @(negedge clk);
        chk("latency_cycle2", int'(bus.check_valid), 1);
        @(posedge clk); #1;

        // ADD with carry out, correct and with the carry dropped.
        issue(2, 768, 512, 256, 1, 0);
        issue(2, 768, 512, 256, 0, 0);
        drain();
        do_clear();
        check_idle_zero("clear1");

        // Signed vs unsigned compare, then SUB with a wrong zero flag.
        issue(7, 512, 511, 1, 0, 0);
        issue(5, 512, 511, 1, 0, 0);
        issue(6, 512, 512, 0, 0, 0);
        drain();

        // Random traffic with idle gaps and occasional corrupted responses.
        for (int i = 0; i < 400; i++) begin
            int op, a, b, r, ec, ez, o, c, z, k;
            op = int'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            ref_alu(op, a, b, r, ec, ez);
            o = r; c = ec; z = ez;
            k = int'($urandom_range(0, 9));
            if (k == 0)      o = (r + 1 + int'($urandom_range(0, MAXV - 2))) % MAXV;
            else if (k == 1) z = 1 - ez;
            else if (k == 2) c = 1 - ec;
            issue(op, a, b, o, c, z);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Clear in the cycle a check would complete: the check is dropped.
        bus.ctl = 3'(0); bus.in1 = '0; bus.in2 = '0; bus.out = '0; bus.zero = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        do_clear();
        check_idle_zero("clear_flush");
        repeat (3) @(posedge clk);
        #1;

        // Stop on first failure: later transactions, in flight or new, are discarded.
        stop_on_fail = 1'b1;
        issue(0, 5, 3, 1, 0, 0);
        issue(1, 5, 3, 7, 0, 0);
        issue(3, 5, 3, 5, 0, 0);
        issue(2, 1, 1, 2, 0, 0);
        issue(2, 1, 2, 3, 0, 0);
        issue(2, 3, 1, 4, 0, 0);
        drain();
        @(negedge clk);
        chk("halt_state", int'(halted), 1);
        chk("halt_fail_count", int'(fail_count), 1);
        chk("halt_pass_count", int'(pass_count), 2);
        @(posedge clk); #1;
        issue(2, 1, 1, 2, 0, 0);
        drain();
        do_clear();
        stop_on_fail = 1'b0;
        check_idle_zero("halt_clear");

        // Reset while a transaction is in flight.
        issue(2, 1, 1, 5, 0, 0);
        sb_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_idle_zero("reset_flush");

        // Saturate the fail total, then push past the limit.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            issue(0, 0, 0, 1, 0, 0);
        end
        drain();
        @(negedge clk);
        chk("fail_saturated", int'(fail_count), CNT_MAX);
        @(posedge clk); #1;
        issue(0, 3, 1, 1, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
